serial_adder_ctrl: RTL and testbench

- Sequencer that computes a WIDTH-bit add (lhs + rhs + cin) by running one narrow SLICE-bit ripple adder over successive operand slices, LSB slice first.
- A registered carry chains the slices together.
- Sits between a valid/ready producer and a valid/ready consumer.
- Trades latency (NSLICES cycles) for a single small adder instance.

---
 rtl/serial_adder_ctrl_pkg.sv | 20 ++
 rtl/serial_adder_ctrl_adder_slice.sv | 15 +
 rtl/serial_adder_ctrl.sv | 115 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the slice-serial adder: controller state encoding
// and helpers that derive slice count and counter width from the parameters.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int calc_nslices(input int width, input int slice);
        return width / slice;
    endfunction

    // A single-slice configuration still needs a 1-bit counter to compare against 0.
    function automatic int calc_cnt_w(input int nslices);
        return (nslices <= 1) ? 1 : $clog2(nslices);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_adder_slice.sv
// Purely combinational SLICE-bit ripple adder shared across all operand slices.
module adder_slice #(
    parameter int SLICE = 2
) (
    input  logic             io_cin,
    input  logic [SLICE-1:0] io_lhs,
    input  logic [SLICE-1:0] io_rhs,
    output logic [SLICE-1:0] io_out,
    output logic             io_cout
);

    // Zero-extend to SLICE+1 bits so the MSB of the result is the carry out.
    assign {io_cout, io_out} = {1'b0, io_lhs} + {1'b0, io_rhs} + {{SLICE{1'b0}}, io_cin};

endmodule

// File: rtl/serial_adder_ctrl.sv
// Valid/ready wrapped WIDTH-bit adder that reuses one SLICE-bit adder over
// NSLICES cycles, LSB slice first, chaining slices through a carry register.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_lhs,
    input  logic [WIDTH-1:0] io_in_rhs,
    input  logic             io_in_cin,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_sum,
    output logic             io_out_cout,
    output logic             io_busy
);

    localparam int NSLICES = calc_nslices(WIDTH, SLICE);
    localparam int CNT_W   = calc_cnt_w(NSLICES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICES - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_lhs;
    logic [WIDTH-1:0] r_rhs;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic [SLICE-1:0] w_slice_sum;
    logic             w_slice_cout;
    logic [WIDTH-1:0] w_sum_shifted;

    adder_slice #(
        .SLICE(SLICE)
    ) u_adder_slice (
        .io_cin  (r_carry),
        .io_lhs  (r_lhs[SLICE-1:0]),
        .io_rhs  (r_rhs[SLICE-1:0]),
        .io_out  (w_slice_sum),
        .io_cout (w_slice_cout)
    );

    // Each slice result enters at the MSB end, so after NSLICES shifts the
    // first (LSB) slice has arrived at bit 0.
    generate
        if (NSLICES == 1) begin : g_single
            assign w_sum_shifted = w_slice_sum;
        end else begin : g_multi
            assign w_sum_shifted = {w_slice_sum, r_sum[WIDTH-1:SLICE]};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (io_in_valid)        w_state_next = ST_RUN;
            ST_RUN:  if (r_cnt == LAST_CNT)  w_state_next = ST_DONE;
            ST_DONE: if (io_out_ready)       w_state_next = ST_IDLE;
            default:                         w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lhs   <= '0;
            r_rhs   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_in_valid) begin
                        r_lhs   <= io_in_lhs;
                        r_rhs   <= io_in_rhs;
                        r_carry <= io_in_cin;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sum   <= w_sum_shifted;
                    r_lhs   <= r_lhs >> SLICE;
                    r_rhs   <= r_rhs >> SLICE;
                    r_carry <= w_slice_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake flags depend only on the state register.
    assign io_in_ready  = (r_state == ST_IDLE);
    assign io_out_valid = (r_state == ST_DONE);
    assign io_busy      = (r_state != ST_IDLE);
    assign io_out_sum   = r_sum;
    assign io_out_cout  = r_carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit/2-bit-slice instance and a
// 2-bit single-slice instance sharing clock and reset.
module tb_serial_adder_ctrl;

    logic clk;
    logic reset;

    logic       in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
    logic [7:0] in_lhs, in_rhs, out_sum;

    logic       s_in_valid, s_in_ready, s_in_cin, s_out_valid, s_out_ready, s_out_cout, s_busy;
    logic [1:0] s_in_lhs, s_in_rhs, s_out_sum;

    int tests;
    int fails;

    serial_adder_ctrl #(.WIDTH(8), .SLICE(2)) u_dut8 (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (in_valid),
        .io_in_ready  (in_ready),
        .io_in_lhs    (in_lhs),
        .io_in_rhs    (in_rhs),
        .io_in_cin    (in_cin),
        .io_out_valid (out_valid),
        .io_out_ready (out_ready),
        .io_out_sum   (out_sum),
        .io_out_cout  (out_cout),
        .io_busy      (busy)
    );

    serial_adder_ctrl #(.WIDTH(2), .SLICE(2)) u_dut2 (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (s_in_valid),
        .io_in_ready  (s_in_ready),
        .io_in_lhs    (s_in_lhs),
        .io_in_rhs    (s_in_rhs),
        .io_in_cin    (s_in_cin),
        .io_out_valid (s_out_valid),
        .io_out_ready (s_out_ready),
        .io_out_sum   (s_out_sum),
        .io_out_cout  (s_out_cout),
        .io_busy      (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] lhs;
        logic [7:0] rhs;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction on the 8-bit instance, checking latency and result.
    task automatic run_op(input logic [7:0] l, input logic [7:0] r, input logic c,
                          input logic [7:0] es, input logic ec, input string nm);
        int lat;
        @(negedge clk);
        chk({nm, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_lhs = l; in_rhs = r; in_cin = c;
        @(posedge clk); #1;
        in_valid = 1'b0; in_lhs = 8'($urandom); in_rhs = 8'($urandom); in_cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, ".latency"}, lat, 32'd4);
        chk({nm, ".sum"}, {24'd0, out_sum}, {24'd0, es});
        chk({nm, ".cout"}, {31'd0, out_cout}, {31'd0, ec});
        $display("[TB] %s: 0x%02h+0x%02h+%0d -> sum=0x%02h cout=%0d lat=%0d",
                 nm, l, r, c, out_sum, out_cout, lat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, ".idle_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int acc_k;
        int out_k;
        int cycle;
        int acc_cyc[3];
        logic [8:0] ref_val;

        tests = 0; fails = 0;
        in_valid = 0; in_lhs = 0; in_rhs = 0; in_cin = 0; out_ready = 0;
        s_in_valid = 0; s_in_lhs = 0; s_in_rhs = 0; s_in_cin = 0; s_out_ready = 0;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[4] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        reset = 1'b1;
        #1;
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.sum", {24'd0, out_sum}, 32'd0);
        chk("reset.cout", {31'd0, out_cout}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].lhs, vecs[i].rhs, vecs[i].cin, vecs[i].sum, vecs[i].cout,
                   $sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while new requests are ignored.
        @(negedge clk);
        in_valid = 1'b1; in_lhs = 8'h12; in_rhs = 8'h34; in_cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp.latency", lat, 32'd4);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid; in_lhs = 8'($urandom); in_rhs = 8'($urandom);
            @(posedge clk); #1;
            chk($sformatf("bp.hold%0d.sum", i), {24'd0, out_sum}, 32'h46);
            chk($sformatf("bp.hold%0d.in_ready", i), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp.hold%0d.out_valid", i), {31'd0, out_valid}, 32'd1);
        end
        $display("[TB] backpressure: 0x12+0x34 held sum=0x%02h for 5 cycles", out_sum);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("bp.no_accept_in_done", {31'd0, busy}, 32'd0);
        chk("bp.sum_kept", {24'd0, out_sum}, 32'h46);
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "bp.next");

        // Asynchronous reset in the middle of a RUN.
        @(negedge clk);
        in_valid = 1'b1; in_lhs = 8'hAA; in_rhs = 8'h55; in_cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst.busy_before", {31'd0, busy}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.sum", {24'd0, out_sum}, 32'd0);
        chk("rst.cout", {31'd0, out_cout}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst.discarded", {31'd0, out_valid}, 32'd0);
        $display("[TB] mid-run reset: in-flight 0xAA+0x55 discarded");
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "rst.next");

        // Single-slice instance: one RUN cycle.
        @(negedge clk);
        chk("n1.in_ready", {31'd0, s_in_ready}, 32'd1);
        s_in_valid = 1'b1; s_in_lhs = 2'd2; s_in_rhs = 2'd3; s_in_cin = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("n1.latency", lat, 32'd1);
        chk("n1.sum", {30'd0, s_out_sum}, 32'd2);
        chk("n1.cout", {31'd0, s_out_cout}, 32'd1);
        $display("[TB] nslices1: 2+3+1 -> sum=%0d cout=%0d lat=%0d", s_out_sum, s_out_cout, lat);
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        chk("n1.idle_after", {31'd0, s_in_ready}, 32'd1);

        // Back-to-back: valid held high, consumer always ready.
        out_ready = 1'b1;
        acc_k = 0; out_k = 0; cycle = 0;
        while (out_k < 3 && cycle < 200) begin
            @(negedge clk);
            cycle++;
            if (out_valid) begin
                ref_val = {1'b0, vecs[out_k].lhs} + {1'b0, vecs[out_k].rhs} + {8'd0, vecs[out_k].cin};
                chk($sformatf("b2b%0d.sum", out_k), {24'd0, out_sum}, {24'd0, ref_val[7:0]});
                chk($sformatf("b2b%0d.cout", out_k), {31'd0, out_cout}, {31'd0, ref_val[8]});
                $display("[TB] b2b%0d: sum=0x%02h cout=%0d accepted at cycle %0d",
                         out_k, out_sum, out_cout, acc_cyc[out_k]);
                out_k++;
            end
            if (in_ready) begin
                if (acc_k < 3) begin
                    in_valid = 1'b1; in_lhs = vecs[acc_k].lhs; in_rhs = vecs[acc_k].rhs;
                    in_cin = vecs[acc_k].cin;
                    acc_cyc[acc_k] = cycle;
                    acc_k++;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                in_lhs = 8'($urandom); in_rhs = 8'($urandom);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b.outputs", out_k, 32'd3);
        chk("b2b.gap01", acc_cyc[1] - acc_cyc[0], 32'd6);
        chk("b2b.gap12", acc_cyc[2] - acc_cyc[1], 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
